// File: rtl/dbg_pkg.sv
// Shared definitions for the debug-controller host link: UTAP domain codes,
// default frame geometry and the transmitter state encoding.
package dbg_pkg;

   // UTAP select domains, shared with dbgctl. Domain 0 is never a valid target.
   localparam logic [15:0] UTAP_NONE = 16'h00;
   localparam logic [15:0] UTAP_PC   = 16'h01;

   // Default frame geometry; both ends of the link must agree on these.
   localparam int DBG_FRAME_BITS = 16;
   localparam int DBG_SEL_W      = 3;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      COMMIT,
      GAP
   } dbg_state_t;

endpackage

// File: rtl/dbg_host_tx_if.sv
// Command handshake between a command source and the debug transmitter.
interface dbg_host_tx_if
   import dbg_pkg::*;
#(
   parameter int SEL_W      = DBG_SEL_W,
   parameter int FRAME_BITS = DBG_FRAME_BITS
) ();

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [SEL_W-1:0]      cmd_sel;
   logic [FRAME_BITS-1:0] cmd_data;

   modport master (
      output cmd_valid,
      output cmd_sel,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_sel,
      input  cmd_data,
      output cmd_ready
   );

endinterface

// File: rtl/dbg_piso.sv
// Parallel-load, MSB-first shift register. Load has priority over shift;
// the serial output is always the current MSB.
module dbg_piso #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] par_in,
   output logic             ser_out
);

   logic [WIDTH-1:0] shreg_reg;
   logic [WIDTH-1:0] shreg_next;
   logic [WIDTH-1:0] shifted;

   assign shifted = {shreg_reg[WIDTH-2:0], 1'b0};

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign shreg_next[gi] = load  ? par_in[gi] :
                                 shift ? shifted[gi] : shreg_reg[gi];
      end
   endgenerate

   // Shift register state.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_reg <= '0;
      end else begin
         shreg_reg <= shreg_next;
      end
   end

   assign ser_out = shreg_reg[WIDTH-1];

endmodule

// File: rtl/dbg_host_tx.sv
// Host-side serial transmitter for dbgctl: accepts one command, drives the
// select lines, shifts the payload MSB-first, closes the frame, then samples
// dbgctl's serial reply. Every output is a register loaded from the value it
// must show in the coming cycle, so outputs line up exactly with the state.
module dbg_host_tx
   import dbg_pkg::*;
#(
   parameter int FRAME_BITS = DBG_FRAME_BITS,
   parameter int SEL_W      = DBG_SEL_W,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   dbg_host_tx_if.slave     cmd,
   output logic [SEL_W-1:0] sel_out,
   output logic             dbg_out,
   input  logic             dbg_in,
   output logic             busy,
   output logic             done,
   output logic             resp,
   output logic             err
);

   localparam int BIT_W = $clog2(FRAME_BITS) + 1;
   localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   dbg_state_t       state_reg, state_next;
   logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
   logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
   logic [SEL_W-1:0] sel_lat_reg, sel_lat_next;
   logic [SEL_W-1:0] sel_out_reg, sel_out_next;
   logic             dbg_out_reg, dbg_out_next;
   logic             cmd_ready_reg, cmd_ready_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             resp_reg, resp_next;
   logic             err_reg, err_next;
   logic             piso_load, piso_shift, piso_ser;

   // The payload lives in the shift register; its MSB is the next bit to send.
   dbg_piso #(
      .WIDTH (FRAME_BITS)
   ) u_piso (
      .clk     (clk),
      .rst     (rst),
      .load    (piso_load),
      .shift   (piso_shift),
      .par_in  (cmd.cmd_data),
      .ser_out (piso_ser)
   );

   // Next-state, counters and next output values.
   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      gap_cnt_next = gap_cnt_reg;
      sel_lat_next = sel_lat_reg;
      err_next     = 1'b0;
      piso_load    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cmd.cmd_valid && cmd_ready_reg) begin
               piso_load    = 1'b1;
               sel_lat_next = cmd.cmd_sel;
               if (cmd.cmd_sel == '0) begin
                  err_next = 1'b1;
               end else begin
                  state_next = SETUP;
               end
            end
         end
         SETUP: begin
            state_next = SHIFT;
         end
         SHIFT: begin
            if (bit_cnt_reg == BIT_LAST) begin
               bit_cnt_next = '0;
               state_next   = COMMIT;
            end else begin
               bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            end
         end
         COMMIT: begin
            gap_cnt_next = '0;
            state_next   = GAP;
         end
         GAP: begin
            if (gap_cnt_reg == GAP_LAST) begin
               gap_cnt_next = '0;
               state_next   = IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Every edge that lands in SHIFT advances the payload by one bit, so the
      // MSB captured on that edge is the bit shown during the SHIFT cycle.
      piso_shift = (state_next == SHIFT);

      sel_out_next = '0;
      dbg_out_next = 1'b0;
      if (state_next == SETUP) begin
         sel_out_next = sel_lat_next;
         dbg_out_next = cmd.cmd_data[FRAME_BITS-1];
      end else if (state_next == SHIFT) begin
         sel_out_next = sel_lat_next;
         dbg_out_next = piso_ser;
      end

      cmd_ready_next = (state_next == IDLE);
      busy_next      = (state_next != IDLE);
      done_next      = (state_next == GAP) && (gap_cnt_next == GAP_LAST);

      // dbgctl's reply is valid once the frame has been committed. With a
      // single gap cycle the capture lands one cycle after the done pulse.
      resp_next = ((state_reg == GAP) && (gap_cnt_reg == '0)) ? dbg_in : resp_reg;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         gap_cnt_reg   <= '0;
         sel_lat_reg   <= '0;
         sel_out_reg   <= '0;
         dbg_out_reg   <= 1'b0;
         cmd_ready_reg <= 1'b1;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         resp_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         sel_lat_reg   <= sel_lat_next;
         sel_out_reg   <= sel_out_next;
         dbg_out_reg   <= dbg_out_next;
         cmd_ready_reg <= cmd_ready_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         resp_reg      <= resp_next;
         err_reg       <= err_next;
      end
   end

   assign cmd.cmd_ready = cmd_ready_reg;
   assign sel_out       = sel_out_reg;
   assign dbg_out       = dbg_out_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
   assign resp          = resp_reg;
   assign err           = err_reg;

endmodule

// File: tb/tb_dbg_host_tx.sv
// Self-checking bench for dbg_host_tx: a table of directed commands, hand
// sequences for back-to-back and mid-frame reset, then random commands. The
// expected waveform of a frame is computed from its cycle position.
module tb_dbg_host_tx;
   import dbg_pkg::*;

   localparam int FB = 16;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dbg_in = 1'b0;
   logic [SW-1:0] sel_out;
   logic          dbg_out, busy, done, resp, err;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int err_seen = 0;
   logic last_resp = 1'b0;

   dbg_host_tx_if #(.SEL_W(SW), .FRAME_BITS(FB)) bus ();

   dbg_host_tx #(
      .FRAME_BITS (FB),
      .SEL_W      (SW),
      .GAP_CYCLES (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .cmd     (bus),
      .sel_out (sel_out),
      .dbg_out (dbg_out),
      .dbg_in  (dbg_in),
      .busy    (busy),
      .done    (done),
      .resp    (resp),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && done) done_seen++;
      if (!rst && err)  err_seen++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1);
   end

   typedef struct {
      logic [SW-1:0] sel;
      logic [FB-1:0] data;
      logic          rbit;
      int            exp_done;
      int            exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h", name, act, exp);
      end
   endtask

   // Expected outputs at cycle c after acceptance (cycle 1 = first cycle busy).
   function automatic logic [SW-1:0] exp_sel(int c, logic [SW-1:0] s);
      return (c >= 1 && c <= FB + 1) ? s : '0;
   endfunction

   function automatic logic exp_dbg(int c, logic [FB-1:0] d);
      if (c == 1) return d[FB-1];
      if (c >= 2 && c <= FB + 1) return d[FB + 1 - c];
      return 1'b0;
   endfunction

   task automatic accept(input logic [SW-1:0] s, input logic [FB-1:0] d);
      int waited = 0;
      while (!bus.cmd_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("ready_wait", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = s;
      bus.cmd_data  = d;
      @(posedge clk); #1;
   endtask

   // Check cycles 1..last_c of a frame; dbg_in carries rb in the first GAP cycle.
   task automatic run_cycles(input logic [SW-1:0] s, input logic [FB-1:0] d,
                             input logic rb, input int last_c);
      for (int c = 1; c <= last_c; c++) begin
         chk($sformatf("sel_out c%0d", c), 32'(sel_out), 32'(exp_sel(c, s)));
         chk($sformatf("dbg_out c%0d", c), 32'(dbg_out), 32'(exp_dbg(c, d)));
         chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= FB + 4));
         chk($sformatf("done c%0d", c), 32'(done), 32'(c == FB + 4));
         chk($sformatf("ready c%0d", c), 32'(bus.cmd_ready), 32'(c > FB + 4));
         chk($sformatf("err c%0d", c), 32'(err), 32'd0);
         chk($sformatf("resp c%0d", c), 32'(resp), 32'((c >= FB + 4) ? rb : last_resp));
         dbg_in = (c == FB + 3) ? rb : 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_frame(input logic [SW-1:0] s, input logic [FB-1:0] d, input logic rb);
      accept(s, d);
      bus.cmd_valid = 1'b0;
      bus.cmd_sel   = SW'($urandom);
      bus.cmd_data  = FB'($urandom);
      run_cycles(s, d, rb, FB + 5);
      $display("frame sel=%0d data=%04h resp=%0d", s, d, rb);
      last_resp = rb;
   endtask

   task automatic do_reject(input logic [FB-1:0] d);
      accept('0, d);
      bus.cmd_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("rej err c%0d", c), 32'(err), 32'(c == 1));
         chk($sformatf("rej sel c%0d", c), 32'(sel_out), 32'd0);
         chk($sformatf("rej busy c%0d", c), 32'(busy), 32'd0);
         chk($sformatf("rej done c%0d", c), 32'(done), 32'd0);
         chk($sformatf("rej resp c%0d", c), 32'(resp), 32'(last_resp));
         dbg_in = 1'($urandom);
         @(posedge clk); #1;
      end
      $display("reject data=%04h", d);
   endtask

   vec_t vecs[6];
   localparam logic [SW-1:0] PC_SEL = UTAP_PC[SW-1:0];

   initial begin
      int d0, e0;
      logic [SW-1:0] rs;
      bus.cmd_valid = 1'b0;
      bus.cmd_sel   = '0;
      bus.cmd_data  = '0;

      vecs[0] = '{PC_SEL, 16'h0001, 1'b0, 1, 0};
      vecs[1] = '{3'd1,   16'hA5C3, 1'b1, 1, 0};
      vecs[2] = '{3'd0,   16'hFFFF, 1'b1, 0, 1};
      vecs[3] = '{3'd7,   16'h8000, 1'b0, 1, 0};
      vecs[4] = '{3'd3,   16'hFFFF, 1'b1, 1, 0};
      vecs[5] = '{3'd0,   16'h0000, 1'b0, 0, 1};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst sel_out", 32'(sel_out), 32'd0);
      chk("rst dbg_out", 32'(dbg_out), 32'd0);
      chk("rst ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst resp", 32'(resp), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      $display("reset checked");

      // Directed table.
      for (int i = 0; i < 6; i++) begin
         d0 = done_seen;
         e0 = err_seen;
         if (vecs[i].sel == '0) do_reject(vecs[i].data);
         else do_frame(vecs[i].sel, vecs[i].data, vecs[i].rbit);
         chk($sformatf("vec%0d done count", i), 32'(done_seen - d0), 32'(vecs[i].exp_done));
         chk($sformatf("vec%0d err count", i), 32'(err_seen - e0), 32'(vecs[i].exp_err));
      end

      // Back-to-back: valid held, payload changed mid-frame to the next command.
      accept(3'd1, 16'h0001);
      bus.cmd_sel  = 3'd2;
      bus.cmd_data = 16'h0000;
      run_cycles(3'd1, 16'h0001, 1'b1, FB + 5);
      last_resp = 1'b1;
      bus.cmd_valid = 1'b0;
      run_cycles(3'd2, 16'h0000, 1'b0, FB + 5);
      last_resp = 1'b0;
      $display("back-to-back frames checked");

      // Reset in SHIFT at k=7 (cycle 9 after acceptance).
      accept(3'd5, 16'h1234);
      bus.cmd_valid = 1'b0;
      run_cycles(3'd5, 16'h1234, 1'b0, 8);
      d0 = done_seen;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_resp = 1'b0;
      chk("midrst sel_out", 32'(sel_out), 32'd0);
      chk("midrst dbg_out", 32'(dbg_out), 32'd0);
      chk("midrst ready", 32'(bus.cmd_ready), 32'd1);
      chk("midrst busy", 32'(busy), 32'd0);
      for (int c = 0; c < 25; c++) begin
         chk("midrst idle busy", 32'(busy), 32'd0);
         @(posedge clk); #1;
      end
      chk("midrst no done", 32'(done_seen - d0), 32'd0);
      $display("mid-frame reset checked");

      // Random commands against the frame model.
      for (int i = 0; i < 24; i++) begin
         d0 = done_seen;
         e0 = err_seen;
         rs = SW'($urandom_range(0, 7));
         repeat ($urandom_range(0, 3)) begin
            dbg_in = 1'($urandom);
            @(posedge clk); #1;
         end
         if (rs == '0) do_reject(FB'($urandom));
         else do_frame(rs, FB'($urandom), 1'($urandom));
         chk($sformatf("rnd%0d done count", i), 32'(done_seen - d0), 32'(rs != '0));
         chk($sformatf("rnd%0d err count", i), 32'(err_seen - e0), 32'(rs == '0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
